dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pkg.sv | 21 ++
 rtl/dsp_pipe_reg.sv | 29 ++
 rtl/dsp_mac_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg -- shared definitions for the dsp_mac_pipe slice.
//   OP_*        : bit positions inside the 4-bit OPMODE input
//   OPMODE_W    : OPMODE width
//   opmode_t    : packed view of OPMODE, field order matches the bit indices
package dsp_mac_pkg;

  localparam int unsigned OPMODE_W     = 4;
  localparam int unsigned OP_PREADD_EN = 0;
  localparam int unsigned OP_PRE_SUB   = 1;
  localparam int unsigned OP_ACC       = 2;
  localparam int unsigned OP_POST_SUB  = 3;

  // MSB first so that a cast from OPMODE lands each flag on its bit index.
  typedef struct packed {
    logic post_sub;
    logic acc;
    logic pre_sub;
    logic preadd_en;
  } opmode_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg -- one pipeline stage register of parametric width.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high clear to zero (wins over ce_i)
//   ce_i  : load enable; when low the stage holds its value
//   d_i   : next-state data
//   q_o   : registered data
module dsp_pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (ce_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe -- three-stage signed pre-add / multiply / post-add MAC with
// a valid/ready stream interface and packet accumulation.
//   S1: input registers (A, B, D, C, OPMODE, IN_LAST)
//   S2: pre-adder + multiplier register M
//   S3: post-adder / accumulator register P
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   IN_VALID/IN_READY   : input handshake
//   A, B, D, C          : operands (signed, AW / BW / BW / PW bits)
//   OPMODE[3:0]         : [0] PREADD_EN [1] PRE_SUB [2] ACC [3] POST_SUB
//   IN_LAST             : last beat of an accumulation packet
//   OUT_VALID/OUT_READY : output handshake
//   P, OUT_LAST         : result and its packet-last flag
//   CARRYOUT, OVERFLOW  : bit PW of the PW+1-bit post-add, saturation flag
// Build option: define DSP_MAC_SAT_EN to saturate signed overflow of the
// post-add to the PW-bit limits (and flag OVERFLOW); otherwise it wraps.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int unsigned AW = 18,
  parameter int unsigned BW = 18,
  parameter int unsigned PW = 48
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [AW-1:0]       A,
  input  logic [BW-1:0]       B,
  input  logic [BW-1:0]       D,
  input  logic [PW-1:0]       C,
  input  logic [OPMODE_W-1:0] OPMODE,
  input  logic                IN_LAST,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [PW-1:0]       P,
  output logic                OUT_LAST,
  output logic                CARRYOUT,
  output logic                OVERFLOW
);

  localparam int unsigned MW = AW + BW + 1;

  if (PW < AW + BW + 1) begin : g_bad_pw
    $error("dsp_mac_pipe: PW must be at least AW+BW+1");
  end

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic [PW-1:0] c;
    opmode_t       op;
    logic          last;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic [MW-1:0] m;
    logic [PW-1:0] c;
    logic          acc;
    logic          post_sub;
    logic          last;
  } s2_t;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] p;
    logic          last;
    logic          carry;
    logic          ovf;
  } s3_t;

  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  s3_t           s3_d, s3_q;
  logic [PW-1:0] acc_d, acc_q;
  opmode_t       op_in;
  logic          stall;
  logic          ce;

  // The whole pipe advances or holds as one; only a presented but
  // unaccepted result can stall it.
  assign stall    = s3_q.valid && !OUT_READY;
  assign ce       = !stall;
  assign IN_READY = !stall;

  // ---------------------------------------------------------------- S1
  always_comb begin
    op_in           = '0;
    op_in.preadd_en = OPMODE[OP_PREADD_EN];
    op_in.pre_sub   = OPMODE[OP_PRE_SUB];
    op_in.acc       = OPMODE[OP_ACC];
    op_in.post_sub  = OPMODE[OP_POST_SUB];

    s1_d       = '0;
    s1_d.valid = IN_VALID;
    s1_d.a     = A;
    s1_d.b     = B;
    s1_d.d     = D;
    s1_d.c     = C;
    s1_d.op    = op_in;
    s1_d.last  = IN_LAST;
  end

  dsp_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk_i (CLK),
    .rst_i (RST),
    .ce_i  (ce),
    .d_i   (s1_d),
    .q_o   (s1_q)
  );

  // ---------------------------------------------------------------- S2
  logic [BW:0]   b_x, d_x, pa;
  logic [MW-1:0] a_m, pa_m, m_full;

  always_comb begin
    b_x = {s1_q.b[BW-1], s1_q.b};
    d_x = {s1_q.d[BW-1], s1_q.d};
    if (!s1_q.op.preadd_en) begin
      pa = b_x;
    end else if (s1_q.op.pre_sub) begin
      pa = d_x - b_x;
    end else begin
      pa = d_x + b_x;
    end

    // Operands are sign-extended to the full product width first, so the
    // low MW bits of the unsigned product equal the signed product.
    a_m    = {{(MW - AW){s1_q.a[AW-1]}}, s1_q.a};
    pa_m   = {{(MW - BW - 1){pa[BW]}}, pa};
    m_full = a_m * pa_m;

    s2_d          = '0;
    s2_d.valid    = s1_q.valid;
    s2_d.m        = m_full;
    s2_d.c        = s1_q.c;
    s2_d.acc      = s1_q.op.acc;
    s2_d.post_sub = s1_q.op.post_sub;
    s2_d.last     = s1_q.last;
  end

  dsp_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk_i (CLK),
    .rst_i (RST),
    .ce_i  (ce),
    .d_i   (s2_d),
    .q_o   (s2_q)
  );

  // ---------------------------------------------------------------- S3
  logic [PW-1:0] z;
  logic [PW:0]   z_x, m_x, r;
  logic [PW-1:0] p_next;
  logic          ovf;

  always_comb begin
    z   = s2_q.acc ? acc_q : s2_q.c;
    z_x = {z[PW-1], z};
    m_x = {{(PW + 1 - MW){s2_q.m[MW-1]}}, s2_q.m};
    r   = s2_q.post_sub ? (z_x - m_x) : (z_x + m_x);

`ifdef DSP_MAC_SAT_EN
    // Both operands are sign-extended, so r[PW] is the true sign and a
    // disagreement with r[PW-1] means the result left the PW-bit range.
    ovf = r[PW] ^ r[PW-1];
    if (ovf) begin
      p_next = r[PW] ? {1'b1, {(PW - 1){1'b0}}} : {1'b0, {(PW - 1){1'b1}}};
    end else begin
      p_next = r[PW-1:0];
    end
`else
    ovf    = 1'b0;
    p_next = r[PW-1:0];
`endif

    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    s3_d.p     = p_next;
    s3_d.last  = s2_q.last;
    s3_d.carry = r[PW];
    s3_d.ovf   = ovf;

    // The accumulator tracks the value written to P, but only for real
    // beats; a packet's last beat restarts the running sum at zero.
    if (s2_q.valid) begin
      acc_d = s2_q.last ? '0 : p_next;
    end else begin
      acc_d = acc_q;
    end
  end

  dsp_pipe_reg #(.W($bits(s3_t))) u_s3 (
    .clk_i (CLK),
    .rst_i (RST),
    .ce_i  (ce),
    .d_i   (s3_d),
    .q_o   (s3_q)
  );

  dsp_pipe_reg #(.W(PW)) u_acc (
    .clk_i (CLK),
    .rst_i (RST),
    .ce_i  (ce),
    .d_i   (acc_d),
    .q_o   (acc_q)
  );

  assign OUT_VALID = s3_q.valid;
  assign P         = s3_q.p;
  assign OUT_LAST  = s3_q.last;
  assign CARRYOUT  = s3_q.carry;
  assign OVERFLOW  = s3_q.ovf;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe -- directed self-checking bench for dsp_mac_pipe
// (default parameters; expectations follow DSP_MAC_SAT_EN when defined).
module tb_dsp_mac_pipe;

  localparam int unsigned AW = 18;
  localparam int unsigned BW = 18;
  localparam int unsigned PW = 48;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic [BW-1:0] D;
  logic [PW-1:0] C;
  logic [3:0]    OPMODE;
  logic          IN_LAST;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [PW-1:0] P;
  logic          OUT_LAST;
  logic          CARRYOUT;
  logic          OVERFLOW;

  always #5 CLK = ~CLK;

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .D         (D),
    .C         (C),
    .OPMODE    (OPMODE),
    .IN_LAST   (IN_LAST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .P         (P),
    .OUT_LAST  (OUT_LAST),
    .CARRYOUT  (CARRYOUT),
    .OVERFLOW  (OVERFLOW)
  );

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [BW-1:0] b,
                       input logic [BW-1:0] d, input logic [PW-1:0] c,
                       input logic [3:0] op, input logic last);
    IN_VALID = v;
    A        = a;
    B        = b;
    D        = d;
    C        = c;
    OPMODE   = op;
    IN_LAST  = last;
  endtask

  // One isolated beat: checks the 3-cycle latency and the result fields.
  task automatic single_beat(input string tag, input logic [AW-1:0] a, input logic [BW-1:0] b,
                             input logic [BW-1:0] d, input logic [PW-1:0] c, input logic [3:0] op,
                             input logic [PW-1:0] exp_p, input logic exp_carry, input logic exp_ovf);
    drive(1'b1, a, b, d, c, op, 1'b0);
    tick();
    IN_VALID = 1'b0;
    chk({tag, ".valid_c1"}, 64'(OUT_VALID), 64'd0);
    tick();
    chk({tag, ".valid_c2"}, 64'(OUT_VALID), 64'd0);
    tick();
    chk({tag, ".valid_c3"}, 64'(OUT_VALID), 64'd1);
    chk({tag, ".p"}, 64'(P), 64'(exp_p));
    chk({tag, ".carry"}, 64'(CARRYOUT), 64'(exp_carry));
    chk({tag, ".ovf"}, 64'(OVERFLOW), 64'(exp_ovf));
    chk({tag, ".last"}, 64'(OUT_LAST), 64'd0);
  endtask

  int unsigned   a2   [5] = '{1, 2, 3, 4, 1};
  logic [3:0]    op2  [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
  logic          lst2 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int unsigned   p2   [5] = '{2, 6, 12, 20, 2};

  int unsigned   in_idx;
  int unsigned   out_idx;
  logic          acc_in;
  logic          take_out;
  logic [PW-1:0] p_seen;

  initial begin
    RST       = 1'b1;
    OUT_READY = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    chk("rst.out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst.in_ready", 64'(IN_READY), 64'd1);
    chk("rst.p", 64'(P), 64'd0);
    chk("rst.out_last", 64'(OUT_LAST), 64'd0);
    chk("rst.carry", 64'(CARRYOUT), 64'd0);
    chk("rst.ovf", 64'(OVERFLOW), 64'd0);

    // Pre-adder / post-adder modes.
    single_beat("d_minus_b", 18'd3, 18'd4, 18'd10, 48'd0, 4'b0011, 48'd18, 1'b0, 1'b0);
    single_beat("d_plus_b", 18'd3, 18'd4, 18'd10, 48'd0, 4'b0001, 48'd42, 1'b0, 1'b0);
    single_beat("b_only", 18'd3, 18'd4, 18'd10, 48'd0, 4'b0000, 48'd12, 1'b0, 1'b0);
    single_beat("post_sub", 18'd2, 18'd3, 18'd0, 48'd100, 4'b1000, 48'd94, 1'b0, 1'b0);
    single_beat("neg_carry", 18'd1, 18'd5, 18'd0, 48'd0, 4'b1000, 48'hFFFF_FFFF_FFFB, 1'b1, 1'b0);

    // Post-add range limits.
`ifdef DSP_MAC_SAT_EN
    single_beat("sat_pos", 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 4'b0000,
                48'h7FFF_FFFF_FFFF, 1'b0, 1'b1);
    single_beat("sat_neg", 18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 4'b1000,
                48'h8000_0000_0000, 1'b1, 1'b1);
`else
    single_beat("wrap_pos", 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 4'b0000,
                48'h8000_0000_0000, 1'b0, 1'b0);
    single_beat("wrap_neg", 18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 4'b1000,
                48'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
`endif

    // Accumulation packet followed by the first beat of the next packet.
    for (int unsigned i = 0; i < 7; i++) begin
      if (i < 5) begin
        drive(1'b1, AW'(a2[i]), 18'd2, 18'd0, 48'd0, op2[i], lst2[i]);
      end else begin
        drive(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);
      end
      tick();
      if (i >= 2) begin
        chk($sformatf("acc.valid%0d", i - 2), 64'(OUT_VALID), 64'd1);
        chk($sformatf("acc.p%0d", i - 2), 64'(P), 64'(p2[i - 2]));
        chk($sformatf("acc.last%0d", i - 2), 64'(OUT_LAST), 64'(lst2[i - 2]));
      end
    end
    drive(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);
    tick();
    tick();

    // Six back-to-back beats with OUT_READY low for five cycles.
    in_idx  = 0;
    out_idx = 0;
    for (int unsigned cyc = 0; cyc < 30; cyc++) begin
      if (in_idx < 6) begin
        drive(1'b1, AW'(in_idx + 1), 18'd3, 18'd0, PW'(100 * in_idx), 4'b0000, 1'b0);
      end else begin
        drive(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);
      end
      OUT_READY = !(cyc >= 3 && cyc <= 7);
      #1;
      if (cyc >= 3 && cyc <= 7) begin
        chk($sformatf("stall.in_ready_c%0d", cyc), 64'(IN_READY), 64'd0);
        chk($sformatf("stall.out_valid_c%0d", cyc), 64'(OUT_VALID), 64'd1);
        chk($sformatf("stall.p_hold_c%0d", cyc), 64'(P), 64'(3 * (out_idx + 1) + 100 * out_idx));
      end
      acc_in   = IN_VALID && IN_READY;
      take_out = OUT_VALID && OUT_READY;
      p_seen   = P;
      tick();
      if (acc_in) begin
        in_idx++;
      end
      if (take_out) begin
        if (out_idx < 6) begin
          chk($sformatf("stall.order%0d", out_idx), 64'(p_seen),
              64'(3 * (out_idx + 1) + 100 * out_idx));
        end else begin
          chk("stall.extra_beat", 64'(out_idx), 64'd5);
        end
        out_idx++;
      end
    end
    OUT_READY = 1'b1;
    chk("stall.accepted", 64'(in_idx), 64'd6);
    chk("stall.delivered", 64'(out_idx), 64'd6);

    // Reset with three accumulating beats in flight.
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 18'd1, 18'd2, 18'd0, 48'd0, 4'b0100, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst.out_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst.in_ready", 64'(IN_READY), 64'd1);
    chk("mid_rst.p", 64'(P), 64'd0);
    single_beat("post_rst_acc", 18'd2, 18'd5, 18'd0, 48'd0, 4'b0100, 48'd10, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
